// File: rtl/div_arb_pkg.sv
// -----------------------------------------------------------------------------
// div_arb_pkg
// Shared types and helpers for the divider arbiter slice.
//   state_t : flush/drain controller states (RUN, DRAIN, HALT)
//   id_w()  : width of a requester index for a given requester count
// The tag entry type depends on the top's TAMANYO/NREQ parameters and is
// therefore declared inside div_pipe_arbiter.
// -----------------------------------------------------------------------------
package div_arb_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/Divisor_Segmentado.sv
// -----------------------------------------------------------------------------
// Divisor_Segmentado
// Fully pipelined signed divider, latency TAMANYO+1 cycles, one new
// operation per cycle. Stage 0 captures operand magnitudes and result signs;
// stages 1..TAMANYO each resolve one quotient bit by restoring division.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
// Ports:
//   CLK, RSTa  clock, asynchronous active-low reset
//   Start      in   load new operands into stage 0
//   Num, Den   in   signed dividend / divisor
//   Coc, Res   out  signed quotient / remainder of the operation that
//                   entered TAMANYO+1 cycles earlier (combinational fixup)
// -----------------------------------------------------------------------------
module Divisor_Segmentado #(
  parameter int TAMANYO = 32
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic [TAMANYO-1:0] Num,
  input  logic [TAMANYO-1:0] Den,
  output logic [TAMANYO-1:0] Coc,
  output logic [TAMANYO-1:0] Res
);

  localparam int W = TAMANYO;

  // dvd_q shifts dividend bits out at the top and quotient bits in at the
  // bottom; after W steps it holds the quotient magnitude.
  logic [W-1:0] dvd_q [0:W];
  logic [W-1:0] rem_q [0:W];
  logic [W-1:0] dsr_q [0:W-1];
  logic [W:0]   negq_q;
  logic [W:0]   negr_q;

  logic [W:0]   trial [1:W];
  logic [W-1:0] rem_d [1:W];
  logic [W-1:0] dvd_d [1:W];

  always_comb begin
    for (int k = 1; k <= W; k++) begin
      trial[k] = {rem_q[k-1], dvd_q[k-1][W-1]};
      if (trial[k] >= {1'b0, dsr_q[k-1]}) begin
        rem_d[k] = W'(trial[k] - {1'b0, dsr_q[k-1]});
        dvd_d[k] = {dvd_q[k-1][W-2:0], 1'b1};
      end else begin
        rem_d[k] = trial[k][W-1:0];
        dvd_d[k] = {dvd_q[k-1][W-2:0], 1'b0};
      end
    end
  end

  // NOTE: the datapath registers are reset as well, so Coc/Res are defined
  // (zero) out of reset instead of X, even though no result is valid yet.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      for (int k = 0; k <= W; k++) begin
        dvd_q[k] <= '0;
        rem_q[k] <= '0;
      end
      for (int k = 0; k < W; k++) dsr_q[k] <= '0;
      negq_q <= '0;
      negr_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every stage samples the
      // previous stage's old value and the pipeline shifts exactly one step.
      if (Start) begin
        dvd_q[0]  <= Num[W-1] ? -Num : Num;
        dsr_q[0]  <= Den[W-1] ? -Den : Den;
        rem_q[0]  <= '0;
        negq_q[0] <= Num[W-1] ^ Den[W-1];
        negr_q[0] <= Num[W-1];
      end
      for (int k = 1; k <= W; k++) begin
        dvd_q[k]  <= dvd_d[k];
        rem_q[k]  <= rem_d[k];
        negq_q[k] <= negq_q[k-1];
        negr_q[k] <= negr_q[k-1];
      end
      for (int k = 1; k < W; k++) dsr_q[k] <= dsr_q[k-1];
    end
  end

  assign Coc = negq_q[W] ? -dvd_q[W] : dvd_q[W];
  assign Res = negr_q[W] ? -rem_q[W] : rem_q[W];

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin grant. Scans requesters starting at ptr+1
// (modulo NREQ) and grants the first one that is asserted.
// Ports:
//   req   in  NREQ  request vector (already gated by the caller)
//   ptr   in  ID_W  index of the most recent grant
//   grant out NREQ  one-hot grant, all zero when req is zero
//   idx   out ID_W  index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = id_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] idx
);

  // Walk the priority order backwards so the last hit written is the
  // highest-priority one; this avoids a separate "found" flag.
  always_comb begin : scan
    int slot;
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant = '0;
    idx   = '0;
    slot  = 0;
    for (int off = NREQ; off >= 1; off--) begin
      slot = (int'(ptr) + off) % NREQ;
      if (req[slot]) begin
        grant       = '0;
        grant[slot] = 1'b1;
        idx         = ID_W'(slot);
      end
    end
  end

endmodule

// File: rtl/div_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// div_pipe_arbiter
// Shares one Divisor_Segmentado among NREQ requesters. One division may be
// issued per cycle (round-robin); a tag pipe of the divider's latency carries
// the requester id so each result leaves on the response bus with its owner.
// A flush/drain controller stops issue and reports when the pipe is empty.
// Ports:
//   CLK, RSTa   clock, asynchronous active-low reset
//   req_valid   in   per-requester request valid
//   req_num     in   packed signed dividends, requester i at [i*TAMANYO +: TAMANYO]
//   req_den     in   packed signed divisors, same packing
//   req_ready   out  one-hot combinational grant (only in RUN, gated by flush)
//   rsp_valid   out  single-cycle result strobe, no backpressure
//   rsp_id      out  originating requester
//   rsp_coc     out  signed quotient
//   rsp_res     out  signed remainder
//   rsp_dz      out  divide-by-zero flag (only with DIVARB_DIVZERO_EN)
//   flush       in   level request to stop issuing and drain
//   flush_done  out  pipe empty and no grants (HALT)
//   busy        out  operations in flight
// Build option: define DIVARB_DIVZERO_EN to accept den == 0 requests and
// return quotient all-ones / remainder = dividend with rsp_dz set.
// -----------------------------------------------------------------------------
module div_pipe_arbiter
  import div_arb_pkg::*;
#(
  parameter int TAMANYO = 32,
  parameter int NREQ    = 4
) (
  input  logic                      CLK,
  input  logic                      RSTa,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*TAMANYO-1:0]   req_num,
  input  logic [NREQ*TAMANYO-1:0]   req_den,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [TAMANYO-1:0]        rsp_coc,
  output logic [TAMANYO-1:0]        rsp_res,
`ifdef DIVARB_DIVZERO_EN
  output logic                      rsp_dz,
`endif
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      busy
);

  localparam int LAT   = TAMANYO + 1;
  localparam int ID_W  = id_w(NREQ);
  localparam int CNT_W = $clog2(LAT + 1);

  typedef struct packed {
    logic               v;
    logic [ID_W-1:0]    id;
`ifdef DIVARB_DIVZERO_EN
    logic               dz;
    logic [TAMANYO-1:0] num;
`endif
  } tag_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  tag_t               tag_q [LAT];
  tag_t               tag_in;

  logic [NREQ-1:0]    arb_req;
  logic [NREQ-1:0]    grant;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;
  logic [TAMANYO-1:0] sel_num, sel_den, div_den;
  logic [TAMANYO-1:0] div_coc, div_res;

  // flush gates the grant in the very cycle it is first seen, before the
  // FSM has left RUN.
  assign arb_req = req_valid & {NREQ{(state_q == RUN) && !flush}};

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req   (arb_req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_num   = req_num[grant_idx*TAMANYO +: TAMANYO];
  assign sel_den   = req_den[grant_idx*TAMANYO +: TAMANYO];

`ifdef DIVARB_DIVZERO_EN
  // A zero divisor still occupies a slot; feed 1 so the divider stays benign.
  assign div_den = (sel_den == '0) ? TAMANYO'(1) : sel_den;
`else
  assign div_den = sel_den;
`endif

  Divisor_Segmentado #(.TAMANYO(TAMANYO)) u_div (
    .CLK   (CLK),
    .RSTa  (RSTa),
    .Start (accept),
    .Num   (sel_num),
    .Den   (div_den),
    .Coc   (div_coc),
    .Res   (div_res)
  );

  always_comb begin
    tag_in    = '0;
    tag_in.v  = accept;
    tag_in.id = grant_idx;
`ifdef DIVARB_DIVZERO_EN
    tag_in.dz  = accept && (sel_den == '0);
    tag_in.num = sel_num;
`endif
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, rsp_valid})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = DRAIN;
      DRAIN:   if (inflight_d == '0) state_d = HALT;
      HALT:    if (!flush) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // The tag pipe is cleared on reset so in-flight work is dropped and no
  // stale response strobe can appear afterwards.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q    <= RUN;
      ptr_q      <= ID_W'(NREQ - 1);
      inflight_q <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      if (accept) ptr_q <= grant_idx;
      tag_q[0] <= tag_in;
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign rsp_valid  = tag_q[LAT-1].v;
  assign rsp_id     = tag_q[LAT-1].id;
  assign flush_done = (state_q == HALT);
  assign busy       = (inflight_q != '0);

`ifdef DIVARB_DIVZERO_EN
  assign rsp_dz  = tag_q[LAT-1].dz;
  assign rsp_coc = tag_q[LAT-1].dz ? '1 : div_coc;
  assign rsp_res = tag_q[LAT-1].dz ? tag_q[LAT-1].num : div_res;
`else
  assign rsp_coc = div_coc;
  assign rsp_res = div_res;
`endif

endmodule

// File: tb/tb_div_pipe_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_pipe_arbiter
// Scoreboard bench for div_pipe_arbiter (TAMANYO=8, NREQ=4). Observed
// handshakes push the expected response (computed with plain integer
// division) into a queue; a monitor pops and compares on every rsp_valid.
// Define DIVARB_DIVZERO_EN to also exercise the divide-by-zero option.
// -----------------------------------------------------------------------------
module tb_div_pipe_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int LAT = W + 1;

  logic           CLK = 1'b0;
  logic           RSTa = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_num, req_den;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_coc, rsp_res;
  logic           flush, flush_done, busy;
`ifdef DIVARB_DIVZERO_EN
  logic           rsp_dz;
`endif

  always #5 CLK = ~CLK;

  div_pipe_arbiter #(.TAMANYO(W), .NREQ(N)) dut (
    .CLK        (CLK),
    .RSTa       (RSTa),
    .req_valid  (req_valid),
    .req_num    (req_num),
    .req_den    (req_den),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_coc    (rsp_coc),
    .rsp_res    (rsp_res),
`ifdef DIVARB_DIVZERO_EN
    .rsp_dz     (rsp_dz),
`endif
    .flush      (flush),
    .flush_done (flush_done),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] coc;
    logic [W-1:0] res;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0, fails = 0, cyc = 0;
  int   model_inflight = 0, last_grant = N - 1, rsp_seen = 0;
  bit   arb_chk = 1'b0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: truncating signed division, remainder has dividend's sign.
  function automatic exp_t model(input int id, input logic [W-1:0] n, input logic [W-1:0] d,
                                 input int due);
    exp_t e;
    int ni, di, q, r;
    ni = int'($signed(n));
    di = int'($signed(d));
    e.id = 2'(id);
    e.due = due;
    e.dz = 1'b0;
    if (di == 0) begin
      e.coc = '1;
      e.res = n;
      e.dz  = 1'b1;
    end else begin
      q = ni / di;
      r = ni % di;
      e.coc = q[W-1:0];
      e.res = r[W-1:0];
    end
    return e;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // Monitor: arbitration rule, busy, scoreboard push on handshake / pop on response.
  int           mon_pick, mon_idx;
  logic [N-1:0] mon_gnt;
  exp_t         mon_e;
  always @(negedge CLK) begin
    if (RSTa) begin
      check("busy", busy, model_inflight != 0);
      check("ready_onehot", $countones(req_ready) <= 1, 1'b1);
      if (arb_chk) begin
        mon_pick = rr_pick(req_valid, last_grant);
        mon_gnt = '0;
        if (mon_pick >= 0) mon_gnt[mon_pick] = 1'b1;
        check("grant", req_ready, mon_gnt);
      end
      if ((req_valid & req_ready) != '0) begin
        mon_idx = 0;
        for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) mon_idx = i;
        sb_q.push_back(model(mon_idx, req_num[mon_idx*W +: W], req_den[mon_idx*W +: W], cyc + LAT));
        last_grant = mon_idx;
        model_inflight++;
      end
      if (rsp_valid) begin
        rsp_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          mon_e = sb_q.pop_front();
          model_inflight--;
          check("rsp_id", rsp_id, mon_e.id);
          check("rsp_coc", rsp_coc, mon_e.coc);
          check("rsp_res", rsp_res, mon_e.res);
          check("rsp_cycle", cyc, mon_e.due);
`ifdef DIVARB_DIVZERO_EN
          check("rsp_dz", rsp_dz, mon_e.dz);
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input int n, input int d);
    req_num[i*W +: W] = W'(n);
    req_den[i*W +: W] = W'(d);
  endtask

  task automatic assert_reset();
    RSTa = 1'b0;
    req_valid = '0;
    flush = 1'b0;
    arb_chk = 1'b0;
    sb_q.delete();
    model_inflight = 0;
    last_grant = N - 1;
  endtask

  task automatic do_reset();
    assert_reset();
    repeat (2) @(posedge CLK);
    #1 RSTa = 1'b1;
    arb_chk = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, req_ready, '0);
    check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check({tag, "_rsp_id"}, rsp_id, '0);
    check({tag, "_rsp_coc"}, rsp_coc, '0);
    check({tag, "_rsp_res"}, rsp_res, '0);
    check({tag, "_flush_done"}, flush_done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic random_cycle();
    int d;
    req_valid = N'($urandom);
    for (int i = 0; i < N; i++) begin
      d = int'($urandom_range(255));
`ifdef DIVARB_DIVZERO_EN
      if ($urandom_range(7) == 0) d = 0;
`else
      if (d == 0) d = 1;
`endif
      set_op(i, int'($urandom_range(255)), d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int  t0, seen0;
  bit  got;

  initial begin
    req_valid = '0;
    req_num = '0;
    req_den = '0;
    flush = 1'b0;
    #2 RSTa = 1'b0;
    @(negedge CLK);
    check_zero("reset");
    @(posedge CLK);
    #1 RSTa = 1'b1;
    arb_chk = 1'b1;

    // Single op: requester 2 computes -7/2.
    tick();
    set_op(2, -7, 2);
    req_valid = 4'b0100;
    t0 = cyc;
    tick();
    req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 2 * LAT && !got; k++) begin
      @(negedge CLK);
      if (rsp_valid) got = 1'b1;
    end
    check("single_rsp_seen", got, 1'b1);
    check("single_latency", cyc - t0, LAT);
    check("single_id", rsp_id, 2);
    check("single_coc", rsp_coc, 8'hFD);
    check("single_res", rsp_res, 8'hFF);
    repeat (LAT) tick();

    // All four requesters valid continuously from reset.
    do_reset();
    set_op(0, 100, 7);
    set_op(1, -100, 7);
    set_op(2, 57, -5);
    set_op(3, -128, 3);
    seen0 = rsp_seen;
    req_valid = '1;
    repeat (12) tick();
    req_valid = '0;
    repeat (LAT + 2) tick();
    check("stream_count", rsp_seen - seen0, 12);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      random_cycle();
      tick();
    end
    req_valid = '0;
    repeat (LAT + 2) tick();

    // Flush with five operations in flight.
    do_reset();
    random_cycle();
    req_valid = '1;
    repeat (5) tick();
    seen0 = rsp_seen;
    flush = 1'b1;
    arb_chk = 1'b0;
    @(negedge CLK);
    check("flush_ready_gated", req_ready, '0);
    check("flush_busy", busy, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 3 * LAT && !got; k++) begin
      @(negedge CLK);
      check("drain_ready", req_ready, '0);
      if (flush_done) got = 1'b1;
    end
    check("flush_done_seen", got, 1'b1);
    check("flush_done_busy", busy, 1'b0);
    check("flush_rsp_count", rsp_seen - seen0, 5);
    check("flush_sb_empty", sb_q.size(), 0);
    @(posedge CLK);
    #1 flush = 1'b0;
    @(negedge CLK);
    check("halt_ready", req_ready, '0);
    check("halt_flush_done", flush_done, 1'b1);
    @(posedge CLK);
    #1 arb_chk = 1'b1;
    @(negedge CLK);
    check("resume_ready", req_ready, 4'b0010);
    check("resume_flush_done", flush_done, 1'b0);
    tick();
    req_valid = '0;
    repeat (LAT + 2) tick();

    // Reset three cycles after three accepts.
    do_reset();
    random_cycle();
    req_valid = '1;
    repeat (3) tick();
    req_valid = '0;
    repeat (3) tick();
    assert_reset();
    #1;
    check_zero("midreset");
    repeat (2) @(posedge CLK);
    #1 RSTa = 1'b1;
    arb_chk = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      check("no_stale_rsp", rsp_valid, 1'b0);
    end

    // Simultaneous accept and response with one operation in flight.
    tick();
    set_op(3, 50, -6);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    repeat (LAT - 1) tick();
    set_op(0, -77, 9);
    req_valid = 4'b0001;
    @(negedge CLK);
    check("overlap_rsp_valid", rsp_valid, 1'b1);
    check("overlap_ready", req_ready, 4'b0001);
    check("overlap_busy", busy, 1'b1);
    tick();
    req_valid = '0;
    @(negedge CLK);
    check("overlap_busy_hold", busy, 1'b1);
    check("overlap_rsp_gap", rsp_valid, 1'b0);
    repeat (LAT + 2) tick();
    check("overlap_idle", busy, 1'b0);

`ifdef DIVARB_DIVZERO_EN
    // Divide by zero followed by a normal op from the same requester.
    set_op(1, 25, 0);
    req_valid = 4'b0010;
    tick();
    set_op(1, 25, 5);
    tick();
    req_valid = '0;
    got = 1'b0;
    for (int k = 0; k < 2 * LAT && !got; k++) begin
      @(negedge CLK);
      if (rsp_valid) got = 1'b1;
    end
    check("dz_rsp_seen", got, 1'b1);
    check("dz_coc", rsp_coc, 8'hFF);
    check("dz_res", rsp_res, 8'd25);
    check("dz_flag", rsp_dz, 1'b1);
    @(negedge CLK);
    check("dz_next_valid", rsp_valid, 1'b1);
    check("dz_next_coc", rsp_coc, 8'd5);
    check("dz_next_res", rsp_res, 8'd0);
    check("dz_next_flag", rsp_dz, 1'b0);
    repeat (LAT) tick();
`endif

    repeat (LAT + 2) tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
